// File: rtl/nq_seq_divider.sv
// nq_seq_divider
//   Sequential sign-magnitude N.Q fixed-point divider. Computes
//   dividend / divisor by radix-2 restoring long division, one quotient bit
//   per clock. Operands and result share the N.Q sign-magnitude format:
//   MSB is the sign, the low N-1 bits are the magnitude, and the low Q bits
//   of the magnitude are fraction.
//
// Ports
//   clk             clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   ing_valid       operands valid
//   ing_ready       divider idle and able to accept
//   ing_dividend    sign-magnitude N.Q dividend
//   ing_divisor     sign-magnitude N.Q divisor
//   egr_valid       result valid
//   egr_ready       downstream accepts result
//   egr_quotient    sign-magnitude N.Q quotient (fraction truncated)
//   egr_overflow    quotient magnitude did not fit, or divide by zero
//   egr_div_by_zero divisor magnitude was zero
module nq_seq_divider #(
  parameter int N_BITS_P = 32,
  parameter int Q_BITS_P = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ing_valid,
  output logic                ing_ready,
  input  logic [N_BITS_P-1:0] ing_dividend,
  input  logic [N_BITS_P-1:0] ing_divisor,
  output logic                egr_valid,
  input  logic                egr_ready,
  output logic [N_BITS_P-1:0] egr_quotient,
  output logic                egr_overflow,
  output logic                egr_div_by_zero
);

  localparam int N  = N_BITS_P;
  localparam int L  = N - 1 + Q_BITS_P;   // number of quotient bits
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] L_CNT = CW'(L);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t         state_q;
  logic           sign_q;
  logic           dbz_q;
  logic [L-1:0]   num_q;
  logic [L-1:0]   quo_q;
  logic [N-2:0]   div_q;
  logic [N-1:0]   rem_q;
  logic [CW-1:0]  cnt_q;
  logic           ing_ready_q;
  logic           egr_valid_q;
  logic [N-1:0]   egr_quotient_q;
  logic           egr_overflow_q;
  logic           egr_dbz_q;

  logic [L-1:0]   num_load_d;
  logic [N-1:0]   rem_shift_d;
  logic [N-1:0]   rem_sub_d;
  logic           rem_ge_d;
  logic           ovf_d;

  // Dividend magnitude pre-scaled by 2^Q so the quotient comes out in N.Q.
  assign num_load_d  = L'(ing_dividend[N-2:0]) << Q_BITS_P;

  // Remainder stays below the divisor, so the shifted value fits in N bits.
  assign rem_shift_d = (rem_q << 1) | N'(num_q[L-1]);
  assign rem_ge_d    = rem_shift_d >= {1'b0, div_q};
  assign rem_sub_d   = rem_shift_d - {1'b0, div_q};

  // Any quotient bit above the N-1 magnitude bits means overflow.
  assign ovf_d       = |(quo_q >> (N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sign_q         <= 1'b0;
      dbz_q          <= 1'b0;
      num_q          <= '0;
      quo_q          <= '0;
      div_q          <= '0;
      rem_q          <= '0;
      cnt_q          <= '0;
      ing_ready_q    <= 1'b1;
      egr_valid_q    <= 1'b0;
      egr_quotient_q <= '0;
      egr_overflow_q <= 1'b0;
      egr_dbz_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ing_valid && ing_ready_q) begin
            sign_q      <= ing_dividend[N-1] ^ ing_divisor[N-1];
            num_q       <= num_load_d;
            div_q       <= ing_divisor[N-2:0];
            rem_q       <= '0;
            quo_q       <= '0;
            ing_ready_q <= 1'b0;
            state_q     <= DIVIDE;
            // A zero divisor skips all iterations; the single formatting
            // cycle then emits the all-ones, flagged result.
            if (ing_divisor[N-2:0] == '0) begin
              dbz_q <= 1'b1;
              cnt_q <= '0;
            end else begin
              dbz_q <= 1'b0;
              cnt_q <= L_CNT;
            end
          end
        end
        DIVIDE: begin
          if (cnt_q != '0) begin
            num_q <= num_q << 1;
            if (rem_ge_d) begin
              rem_q <= rem_sub_d;
              quo_q <= {quo_q[L-2:0], 1'b1};
            end else begin
              rem_q <= rem_shift_d;
              quo_q <= {quo_q[L-2:0], 1'b0};
            end
            cnt_q <= cnt_q - CW'(1);
          end else begin
            // Result formatting: magnitude truncated (not saturated).
            egr_valid_q    <= 1'b1;
            egr_quotient_q <= {sign_q, (dbz_q ? {(N-1){1'b1}} : quo_q[N-2:0])};
            egr_overflow_q <= dbz_q | ovf_d;
            egr_dbz_q      <= dbz_q;
            state_q        <= DONE;
          end
        end
        DONE: begin
          if (egr_ready) begin
            egr_valid_q <= 1'b0;
            ing_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ing_ready       = ing_ready_q;
  assign egr_valid       = egr_valid_q;
  assign egr_quotient    = egr_quotient_q;
  assign egr_overflow    = egr_overflow_q;
  assign egr_div_by_zero = egr_dbz_q;

endmodule

// File: tb/tb_nq_seq_divider.sv
// Directed testbench for nq_seq_divider at default parameters (32.15).
module tb_nq_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ing_valid = 1'b0;
  logic        ing_ready;
  logic [31:0] ing_dividend = '0;
  logic [31:0] ing_divisor = '0;
  logic        egr_valid;
  logic        egr_ready = 1'b0;
  logic [31:0] egr_quotient;
  logic        egr_overflow;
  logic        egr_div_by_zero;

  int errs = 0;
  int checks = 0;

  nq_seq_divider #(.N_BITS_P(32), .Q_BITS_P(15)) dut (
    .clk            (clk),
    .rst            (rst),
    .ing_valid      (ing_valid),
    .ing_ready      (ing_ready),
    .ing_dividend   (ing_dividend),
    .ing_divisor    (ing_divisor),
    .egr_valid      (egr_valid),
    .egr_ready      (egr_ready),
    .egr_quotient   (egr_quotient),
    .egr_overflow   (egr_overflow),
    .egr_div_by_zero(egr_div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present operands for one cycle; returns after the accepting edge (+1).
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("ready_before_accept", ing_ready, 1);
    ing_valid    = 1'b1;
    ing_dividend = a;
    ing_divisor  = b;
    @(posedge clk);
    #1;
    ing_valid    = 1'b0;
    ing_dividend = $urandom;   // operands need not be held
    ing_divisor  = $urandom;
  endtask

  // Count edges after acceptance until egr_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (egr_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (egr_valid !== 1'b1) chk("valid_timeout", egr_valid, 1);
  endtask

  task automatic handshake;
    @(negedge clk);
    egr_ready = 1'b1;
    @(posedge clk);
    #1;
    egr_ready = 1'b0;
    chk("hs_valid_low", egr_valid, 0);
    chk("hs_ready_high", ing_ready, 1);
  endtask

  // Watch for a spurious result over a window of cycles.
  task automatic no_valid_for(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (egr_valid === 1'b1) seen = 1'b1;
    end
    chk(tag, seen, 0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        ovf;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    //          dividend       divisor        quotient       ovf   dbz   lat
    vecs[0] = '{32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0, 47}; //  3/2
    vecs[1] = '{32'h8001_8000, 32'h0001_0000, 32'h8000_C000, 1'b0, 1'b0, 47}; // -3/2
    vecs[2] = '{32'h8001_8000, 32'h8001_0000, 32'h0000_C000, 1'b0, 1'b0, 47}; // -3/-2
    vecs[3] = '{32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, 1'b0, 47}; //  1/3
    vecs[4] = '{32'h4000_0000, 32'h0000_4000, 32'h0000_0000, 1'b1, 1'b0, 47}; //  32768/0.5
    vecs[5] = '{32'h0000_8000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1};  //  1/0
    vecs[6] = '{32'h8000_8000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1};  // -1/+0

    // Reset, with ing_valid asserted during reset.
    rst = 1'b1;
    ing_valid = 1'b1;
    ing_dividend = 32'h0001_8000;
    ing_divisor  = 32'h0001_0000;
    @(posedge clk);
    #1;
    chk("rst_valid", egr_valid, 0);
    chk("rst_quot", egr_quotient, 0);
    chk("rst_ovf", egr_overflow, 0);
    chk("rst_dbz", egr_div_by_zero, 0);
    chk("rst_ready", ing_ready, 1);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", egr_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    ing_valid = 1'b0;

    // Directed vectors.
    foreach (vecs[i]) begin
      start(vecs[i].a, vecs[i].b);
      chk("busy_ready_low", ing_ready, 0);
      wait_valid(lat);
      $display("div %h / %h -> q=%h ovf=%b dbz=%b lat=%0d",
               vecs[i].a, vecs[i].b, egr_quotient, egr_overflow, egr_div_by_zero, lat);
      chk("latency", lat, vecs[i].lat);
      chk("quotient", egr_quotient, vecs[i].q);
      chk("overflow", egr_overflow, vecs[i].ovf);
      chk("div_by_zero", egr_div_by_zero, vecs[i].dbz);
      handshake();
    end

    // Backpressure: stall 10 cycles with a competing ing_valid.
    start(32'h0001_8000, 32'h0001_0000);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ing_valid    = 1'b1;
      ing_dividend = 32'h0000_8000;
      ing_divisor  = 32'h0001_8000;
      @(posedge clk);
      #1;
      chk("stall_valid", egr_valid, 1);
      chk("stall_quot", egr_quotient, 32'h0000_C000);
      chk("stall_flags", {egr_overflow, egr_div_by_zero}, 2'b00);
      chk("stall_ready", ing_ready, 0);
    end
    @(negedge clk);
    ing_valid = 1'b0;
    $display("stall 3/2 -> q=%h held 10 cycles", egr_quotient);
    handshake();
    no_valid_for("stall_no_phantom", 60);

    // Reset 20 cycles into a divide aborts it.
    start(32'h0000_8000, 32'h0001_8000);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_valid", egr_valid, 0);
    chk("abort_quot", egr_quotient, 0);
    chk("abort_flags", {egr_overflow, egr_div_by_zero}, 2'b00);
    chk("abort_ready", ing_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    no_valid_for("abort_no_result", 60);
    $display("reset mid-divide: no result emitted");

    // Fresh divide after the abort.
    start(32'h0001_8000, 32'h0001_0000);
    wait_valid(lat);
    $display("div 00018000 / 00010000 -> q=%h lat=%0d (after abort)", egr_quotient, lat);
    chk("post_abort_lat", lat, 47);
    chk("post_abort_quot", egr_quotient, 32'h0000_C000);
    handshake();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
